pm_multi: RTL and testbench
===========================

// Module: pm_multi
// PURPOSE
//  Next-generation performance monitor: CNTNUM programmable counters, each selecting one of EVNUM event
//  lanes, with per-counter privilege filter, shared PID filter, overflow status and interrupt. Sits on
//  the SoC peripheral AXI bus as a 64-bit slave; events come from core pipeline, irq goes to the PLIC.
// PARAMETERS
//  EVNUM   64  number of event lanes (<=256)
//  EVW     4   width of each lane's per-cycle increment
//  CNTNUM  8   number of programmable counters (1..32)
//  CNTW    48  counter width (EVW+1..64); reads zero-extend to 64
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           asynchronous active-low reset
//  level          in   2           current privilege level
//  pid            in   32          current process ID
//  events         in   EVNUM*EVW   per-cycle increment of each event lane
//  irq            out  1           overflow interrupt, level
//  s_axi_aw*/w*/b*/ar*/r*  AXI4-Lite slave: awaddr/araddr 16, wdata/rdata 64, bresp/rresp 2; no strobes
// BEHAVIOUR
//  Map (8-byte stride): 0x000+8i counter i (RW); 0x100+8i cfg i (RW): [7:0] event sel, [11:8] level mask,
//   [12] enable, [13] irq en, [14] pid filter en; 0x200 gctrl (RW): [0] global en, [1] freeze-on-ovf,
//   [63:32] pid match; 0x208 ovf status (RW1C, bits [CNTNUM-1:0]).
//  Unmapped or i>=CNTNUM: read data 0 + resp SLVERR(2'b10), write ignored + SLVERR; mapped -> OKAY.
//  Reserved register bits read 0. Event sel >= EVNUM: counter increments by 0.
//  Count qualify i: gctrl[0] & cfg[12] & cfg[8+level] & (~cfg[14] | pid==gctrl[63:32]) & ~frozen;
//   frozen = gctrl[1] & |ovf. Qualified increment = zero-extended events[sel]; visible next cycle.
//  Overflow: counter+inc wraps modulo 2^CNTW; ovf[i] set same edge. irq = |(ovf & irq_en), registered
//   combinationally from flops (no extra delay after ovf set).
//  Collisions: SW write to counter i same cycle as increment -> write value wins, increment lost.
//   W1C of ovf[i] same cycle as new overflow i -> bit stays set.
//  AXI: after reset arready=awready=wready=1, rvalid=bvalid=0, rdata=0, rresp=bresp=0.
//   AR handshake -> arready=0, rvalid=1 next cycle, rdata = register value at handshake edge;
//   R handshake -> rvalid=0, arready=1. AW and W captured independently (each ready drops on its
//   handshake); cycle after both held, bvalid=1 and write takes effect on that edge; B handshake ->
//   bvalid=0, awready=wready=1. One outstanding read and one outstanding write; read and write
//   channels fully concurrent. Held r/b outputs stable while valid & ~ready.
//  Reset mid-transaction: all state to reset values immediately (async), counters/cfg/gctrl/ovf = 0.
// CONFIGURATION
//  PM_SNAPSHOT_EN defined: write to 0x210 copies all counters into shadow regs (readable at 0x300+8i)
//   on the write-effect edge, and sets gctrl-independent status bit 0x208[32]; RW1C. Same-cycle
//   increment is excluded from the snapshot (pre-increment value).
//  Not defined: 0x210 and 0x300+ are unmapped (SLVERR), no shadow flops, 0x208[32] reads 0.
// STRUCTURE
//  pm_pkg: address offset constants, pm_cfg_t packed struct (sel, lvl_mask, en, irq_en, pid_en),
//   gctrl bit indices, AXI resp constants.
//  Sub-module pm_ctr_slice (one per counter, generate loop): event mux, qualify, add, wrap detect,
//   SW load; top holds AXI FSM, decode, gctrl, ovf, irq, optional shadow.
// TESTING
//  1. cfg0 sel=3 mask=0xF en; gctrl en; events[3]=2 for 10 cycles -> read 0x000 = 20, resp OKAY.
//  2. level=1, cfg1 mask=0x1 -> counter1 holds; switch level=0 -> increments resume next cycle.
//  3. pid filter en, gctrl pid=0x42, pid=0x41 -> no count; pid=0x42 -> counts.
//  4. counter2 loaded 2^48-1, inc 1, irq_en -> counter 0, ovf[2]=1, irq=1; freeze set -> all hold;
//     W1C 0x208=0x4 -> irq=0, counting resumes.
//  5. Write counter0=100 same cycle as inc 5 -> reads 100; read 0x1F8 -> rdata 0, rresp 2'b10.
//  6. W before AW by 3 cycles, bready low 4 cycles -> single B, bvalid held; concurrent read unaffected.

Source files
------------

// File: rtl/pm_pkg.sv
// pm_pkg: shared definitions for the pm_multi performance monitor.
//   Register map offsets, the per-counter config struct, gctrl bit
//   positions, AXI response codes and the small enums used by the top.
//   Optional feature macro used by the design: PM_SNAPSHOT_EN.
package pm_pkg;

  localparam logic [7:0]  PG_CNT   = 8'h00;   // 0x000 + 8i counters
  localparam logic [7:0]  PG_CFG   = 8'h01;   // 0x100 + 8i configs
  localparam logic [7:0]  PG_GLB   = 8'h02;   // 0x200 page: gctrl/ovf/snap
  localparam logic [7:0]  PG_SHD   = 8'h03;   // 0x300 + 8i shadows
  localparam logic [7:0]  OFF_GCTRL = 8'h00;
  localparam logic [7:0]  OFF_OVF   = 8'h08;
  localparam logic [7:0]  OFF_SNAP  = 8'h10;

  localparam int G_EN      = 0;
  localparam int G_FRZ     = 1;
  localparam int G_PID_LSB = 32;
  localparam int SNAP_BIT  = 32;   // snapshot-taken flag inside ovf status

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Field order matches the cfg register layout [14:0].
  typedef struct packed {
    logic       pid_en;    // [14]
    logic       irq_en;    // [13]
    logic       en;        // [12]
    logic [3:0] lvl_mask;  // [11:8]
    logic [7:0] sel;       // [7:0]
  } pm_cfg_t;

  typedef enum logic [2:0] {K_NONE, K_CNT, K_CFG, K_GCTRL, K_OVF, K_SNAP, K_SHD} pm_kind_e;
  typedef enum logic {R_IDLE, R_DATA}    pm_rst_e;
  typedef enum logic {W_COLLECT, W_RESP} pm_wst_e;

endpackage

// File: rtl/pm_multi_if.sv
// pm_multi_if: 64-bit AXI4-Lite bus (no strobes) between the SoC
//   interconnect (master) and pm_multi (slave). 16-bit addresses.
interface pm_multi_if;
  logic        awvalid, awready;
  logic [15:0] awaddr;
  logic        wvalid, wready;
  logic [63:0] wdata;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [15:0] araddr;
  logic        rvalid, rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;

  modport master (output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
                  input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp);
  modport slave  (input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
                  output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp);
endinterface

// File: rtl/pm_ctr_slice.sv
// pm_ctr_slice: one programmable counter.
//   Selects an event lane, applies enable/privilege/PID qualification,
//   adds the lane increment with wrap detection, and accepts SW loads.
// Ports: clk, rst_n; cfg_i (counter config); gate_i (global enable and not
//   frozen); pid_ok_i (pid matches gctrl); level_i; events_i (all lanes);
//   wr_i/wr_data_i (SW load); cnt_o (counter value); ovf_o (wrap this edge).
module pm_ctr_slice
  import pm_pkg::*;
#(
  parameter int EVNUM = 64,
  parameter int EVW   = 4,
  parameter int CNTW  = 48
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  pm_cfg_t                cfg_i,
  input  logic                   gate_i,
  input  logic                   pid_ok_i,
  input  logic [1:0]             level_i,
  input  logic [EVNUM*EVW-1:0]   events_i,
  input  logic                   wr_i,
  input  logic [CNTW-1:0]        wr_data_i,
  output logic [CNTW-1:0]        cnt_o,
  output logic                   ovf_o
);
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [EVW-1:0]  ev, inc;
  logic            qual;
  logic [CNTW:0]   sum;

  // Select lanes >= EVNUM never match, so they contribute 0.
  always_comb begin
    ev = '0;
    for (int e = 0; e < EVNUM; e++)
      if (cfg_i.sel == 8'(e)) ev = events_i[e*EVW +: EVW];
  end

  assign qual  = gate_i & cfg_i.en & cfg_i.lvl_mask[level_i] & (~cfg_i.pid_en | pid_ok_i);
  assign inc   = qual ? ev : '0;
  assign sum   = {1'b0, cnt_q} + {{(CNTW+1-EVW){1'b0}}, inc};
  // A SW load replaces the increment entirely, including any wrap it would cause.
  assign cnt_d = wr_i ? wr_data_i : sum[CNTW-1:0];
  assign ovf_o = ~wr_i & sum[CNTW];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pm_multi.sv
// pm_multi: performance monitor with CNTNUM programmable counters on a
//   64-bit AXI4-Lite slave.
// Ports: clk, rst_n (async active low); level (privilege); pid (process id);
//   events (EVNUM lanes of EVW-bit increments); irq (level overflow irq);
//   s_axi (pm_multi_if.slave register bus).
// Optional feature macro: PM_SNAPSHOT_EN (counter snapshot at 0x210, shadow
//   registers at 0x300+8i, snapshot flag at 0x208[32]).
module pm_multi
  import pm_pkg::*;
#(
  parameter int EVNUM  = 64,
  parameter int EVW    = 4,
  parameter int CNTNUM = 8,
  parameter int CNTW   = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           level,
  input  logic [31:0]          pid,
  input  logic [EVNUM*EVW-1:0] events,
  output logic                 irq,
  pm_multi_if.slave            s_axi
);
  // Unaligned or out-of-range addresses decode to K_NONE (SLVERR).
  function automatic pm_kind_e decode(input logic [15:0] a);
    logic idx_ok;
    idx_ok = int'(a[7:3]) < CNTNUM;
    decode = K_NONE;
    if (a[2:0] == 3'd0)
      case (a[15:8])
        PG_CNT: if (idx_ok) decode = K_CNT;
        PG_CFG: if (idx_ok) decode = K_CFG;
        PG_GLB:
          case (a[7:0])
            OFF_GCTRL: decode = K_GCTRL;
            OFF_OVF:   decode = K_OVF;
`ifdef PM_SNAPSHOT_EN
            OFF_SNAP:  decode = K_SNAP;
`endif
            default: ;
          endcase
`ifdef PM_SNAPSHOT_EN
        PG_SHD: if (idx_ok) decode = K_SHD;
`endif
        default: ;
      endcase
  endfunction

  pm_cfg_t                      cfg_q [CNTNUM];
  logic [CNTNUM-1:0][CNTW-1:0]  cnt;
  logic [CNTNUM-1:0]            ovf_q, ovf_set, cnt_wr, irq_en, w1c;
  logic                         gen_q, frz_q, gate, pid_ok;
  logic [31:0]                  pidm_q;

  // ---------------- write channel ----------------
  pm_wst_e     wst_q, wst_d;
  logic        aw_got_q, w_got_q, do_wr;
  logic [15:0] awaddr_q;
  logic [63:0] wdata_q;
  logic [1:0]  bresp_q;
  pm_kind_e    wr_kind;
  logic [4:0]  wr_idx;

  assign do_wr   = (wst_q == W_COLLECT) & aw_got_q & w_got_q;
  assign wr_kind = decode(awaddr_q);
  assign wr_idx  = awaddr_q[7:3];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wst_q <= W_COLLECT;
    else        wst_q <= wst_d;

  always_comb begin
    wst_d = wst_q;
    case (wst_q)
      W_COLLECT: if (do_wr) wst_d = W_RESP;
      W_RESP:    if (s_axi.bready) wst_d = W_COLLECT;
      default:   wst_d = W_COLLECT;
    endcase
  end

  always_comb begin
    s_axi.awready = (wst_q == W_COLLECT) & ~aw_got_q;
    s_axi.wready  = (wst_q == W_COLLECT) & ~w_got_q;
    s_axi.bvalid  = (wst_q == W_RESP);
    s_axi.bresp   = bresp_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      aw_got_q <= 1'b0; w_got_q <= 1'b0;
      awaddr_q <= '0;   wdata_q <= '0; bresp_q <= RESP_OKAY;
    end else begin
      if (s_axi.awvalid & s_axi.awready) begin aw_got_q <= 1'b1; awaddr_q <= s_axi.awaddr; end
      if (s_axi.wvalid & s_axi.wready)   begin w_got_q  <= 1'b1; wdata_q  <= s_axi.wdata;  end
      if (do_wr) begin
        aw_got_q <= 1'b0; w_got_q <= 1'b0;
        bresp_q  <= (wr_kind == K_NONE) ? RESP_SLVERR : RESP_OKAY;
      end
    end

  // ---------------- counters ----------------
  assign gate   = gen_q & ~(frz_q & |ovf_q);
  assign pid_ok = (pid == pidm_q);

  for (genvar i = 0; i < CNTNUM; i++) begin : g_ctr
    assign cnt_wr[i] = do_wr & (wr_kind == K_CNT) & (wr_idx == 5'(i));
    assign irq_en[i] = cfg_q[i].irq_en;
    pm_ctr_slice #(.EVNUM(EVNUM), .EVW(EVW), .CNTW(CNTW)) u_ctr (
      .clk(clk), .rst_n(rst_n), .cfg_i(cfg_q[i]), .gate_i(gate), .pid_ok_i(pid_ok),
      .level_i(level), .events_i(events), .wr_i(cnt_wr[i]), .wr_data_i(wdata_q[CNTW-1:0]),
      .cnt_o(cnt[i]), .ovf_o(ovf_set[i]));
  end

  // New overflow beats a same-cycle W1C of the same bit.
  assign w1c = (do_wr & (wr_kind == K_OVF)) ? wdata_q[CNTNUM-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < CNTNUM; i++) cfg_q[i] <= '0;
      gen_q <= 1'b0; frz_q <= 1'b0; pidm_q <= '0; ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_q & ~w1c) | ovf_set;
      if (do_wr & (wr_kind == K_CFG))
        for (int i = 0; i < CNTNUM; i++)
          if (wr_idx == 5'(i)) cfg_q[i] <= wdata_q[$bits(pm_cfg_t)-1:0];
      if (do_wr & (wr_kind == K_GCTRL)) begin
        gen_q  <= wdata_q[G_EN];
        frz_q  <= wdata_q[G_FRZ];
        pidm_q <= wdata_q[G_PID_LSB +: 32];
      end
    end

  assign irq = |(ovf_q & irq_en);

`ifdef PM_SNAPSHOT_EN
  logic [CNTNUM-1:0][CNTW-1:0] shd_q;
  logic                        snap_q;
  // Captures the flop values, i.e. the pre-increment count of that edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shd_q <= '0; snap_q <= 1'b0;
    end else if (do_wr & (wr_kind == K_SNAP)) begin
      shd_q <= cnt; snap_q <= 1'b1;
    end else if (do_wr & (wr_kind == K_OVF) & wdata_q[SNAP_BIT]) begin
      snap_q <= 1'b0;
    end
`endif

  // ---------------- read channel ----------------
  pm_rst_e     rst_q, rst_d;
  pm_kind_e    rd_kind;
  logic [4:0]  rd_idx;
  logic [63:0] rd_val, rdata_q;
  logic [1:0]  rresp_q;
  logic        ar_hs;

  assign ar_hs   = s_axi.arvalid & s_axi.arready;
  assign rd_kind = decode(s_axi.araddr);
  assign rd_idx  = s_axi.araddr[7:3];

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < CNTNUM; i++)
      if (rd_idx == 5'(i)) begin
        if (rd_kind == K_CNT) rd_val = 64'(cnt[i]);
        if (rd_kind == K_CFG) rd_val = 64'(cfg_q[i]);
`ifdef PM_SNAPSHOT_EN
        if (rd_kind == K_SHD) rd_val = 64'(shd_q[i]);
`endif
      end
    if (rd_kind == K_GCTRL) rd_val = {pidm_q, 30'd0, frz_q, gen_q};
`ifdef PM_SNAPSHOT_EN
    if (rd_kind == K_OVF)   rd_val = {31'd0, snap_q, 32'(ovf_q)};
`else
    if (rd_kind == K_OVF)   rd_val = {32'd0, 32'(ovf_q)};
`endif
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_q <= R_IDLE;
    else        rst_q <= rst_d;

  always_comb begin
    rst_d = rst_q;
    case (rst_q)
      R_IDLE:  if (ar_hs) rst_d = R_DATA;
      R_DATA:  if (s_axi.rready) rst_d = R_IDLE;
      default: rst_d = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi.arready = (rst_q == R_IDLE);
    s_axi.rvalid  = (rst_q == R_DATA);
    s_axi.rdata   = rdata_q;
    s_axi.rresp   = rresp_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdata_q <= '0; rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= (rd_kind == K_NONE) ? '0 : rd_val;
      rresp_q <= (rd_kind == K_NONE) ? RESP_SLVERR : RESP_OKAY;
    end
endmodule

// File: tb/tb_pm_multi.sv
// tb_pm_multi: directed, table-driven bench for pm_multi (default params).
module tb_pm_multi;
  localparam int EVNUM = 64, EVW = 4, CNTNUM = 8, CNTW = 48;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] level = 2'd0;
  logic [31:0] pid = 32'd0;
  logic [EVNUM*EVW-1:0] events = '0;
  logic irq;
  int total = 0, bad = 0;

  pm_multi_if axi();

  pm_multi #(.EVNUM(EVNUM), .EVW(EVW), .CNTNUM(CNTNUM), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .level(level), .pid(pid), .events(events), .irq(irq), .s_axi(axi));

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [63:0] data;
    logic [63:0] exp;
    logic [1:0]  resp;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_ev(input int lane, input logic [EVW-1:0] v);
    events[lane*EVW +: EVW] = v;
  endtask

  task automatic axi_write(input logic [15:0] a, input logic [63:0] d, output logic [1:0] resp);
    int n; logic aw_p, w_p;
    @(negedge clk);
    axi.awaddr = a; axi.wdata = d; axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b1;
    n = 0; resp = 2'b11;
    while ((axi.awvalid || axi.wvalid) && n < 50) begin
      aw_p = axi.awready; w_p = axi.wready;
      @(negedge clk); n++;
      if (aw_p) axi.awvalid = 1'b0;
      if (w_p)  axi.wvalid  = 1'b0;
    end
    while (!axi.bvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL write timeout addr %h", a);
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    end else resp = axi.bresp;
    @(negedge clk); axi.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [15:0] a, output logic [63:0] d, output logic [1:0] resp);
    int n; logic p;
    @(negedge clk);
    axi.araddr = a; axi.arvalid = 1'b1; axi.rready = 1'b1;
    n = 0; resp = 2'b11; d = 'x;
    while (axi.arvalid && n < 50) begin
      p = axi.arready;
      @(negedge clk); n++;
      if (p) axi.arvalid = 1'b0;
    end
    while (!axi.rvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL read timeout addr %h", a);
      axi.arvalid = 1'b0;
    end else begin d = axi.rdata; resp = axi.rresp; end
    @(negedge clk); axi.rready = 1'b0;
  endtask

  task automatic wr_ok(input logic [15:0] a, input logic [63:0] d);
    logic [1:0] r;
    axi_write(a, d, r);
    chk($sformatf("wresp %h", a), 64'(r), 64'(2'b00));
  endtask

  task automatic rd_chk(input logic [15:0] a, input logic [63:0] exp);
    logic [63:0] d; logic [1:0] r;
    axi_read(a, d, r);
    chk($sformatf("rdata %h", a), d, exp);
    chk($sformatf("rresp %h", a), 64'(r), 64'(2'b00));
  endtask

  initial begin
    logic [63:0] d; logic [1:0] r;
    axi.awvalid = 0; axi.awaddr = 0; axi.wvalid = 0; axi.wdata = 0; axi.bready = 0;
    axi.arvalid = 0; axi.araddr = 0; axi.rready = 0;

    // wr, addr, data, expected rdata, expected resp
    tbl.push_back('{1'b0, 16'h0000, 64'h0, 64'h0, 2'b00});
    tbl.push_back('{1'b0, 16'h0208, 64'h0, 64'h0, 2'b00});
    tbl.push_back('{1'b0, 16'h0200, 64'h0, 64'h0, 2'b00});
    tbl.push_back('{1'b1, 16'h0100, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 2'b00});
    tbl.push_back('{1'b0, 16'h0100, 64'h0, 64'h0000_0000_0000_7FFF, 2'b00});
    tbl.push_back('{1'b1, 16'h0100, 64'h0, 64'h0, 2'b00});
    tbl.push_back('{1'b1, 16'h0200, 64'h1234_5678_0000_00FC, 64'h0, 2'b00});
    tbl.push_back('{1'b0, 16'h0200, 64'h0, 64'h1234_5678_0000_0000, 2'b00});
    tbl.push_back('{1'b1, 16'h0200, 64'h0, 64'h0, 2'b00});
    tbl.push_back('{1'b0, 16'h0040, 64'h0, 64'h0, 2'b10});
    tbl.push_back('{1'b0, 16'h0140, 64'h0, 64'h0, 2'b10});
    tbl.push_back('{1'b1, 16'h0040, 64'h55, 64'h0, 2'b10});
    tbl.push_back('{1'b1, 16'h0140, 64'hFFFF, 64'h0, 2'b10});
    tbl.push_back('{1'b0, 16'h0100, 64'h0, 64'h0, 2'b00});
    tbl.push_back('{1'b0, 16'h01F8, 64'h0, 64'h0, 2'b10});
`ifdef PM_SNAPSHOT_EN
    tbl.push_back('{1'b0, 16'h0300, 64'h0, 64'h0, 2'b00});
`else
    tbl.push_back('{1'b0, 16'h0300, 64'h0, 64'h0, 2'b10});
    tbl.push_back('{1'b1, 16'h0210, 64'h1, 64'h0, 2'b10});
`endif
    tbl.push_back('{1'b1, 16'h0038, 64'hFFFF_0000_0000_0005, 64'h0, 2'b00});
    tbl.push_back('{1'b0, 16'h0038, 64'h0, 64'h5, 2'b00});

    repeat (3) @(negedge clk);
    // reset state of the bus outputs
    chk("rst arready", 64'(axi.arready), 64'd1);
    chk("rst awready", 64'(axi.awready), 64'd1);
    chk("rst wready",  64'(axi.wready),  64'd1);
    chk("rst rvalid",  64'(axi.rvalid),  64'd0);
    chk("rst bvalid",  64'(axi.bvalid),  64'd0);
    chk("rst rdata",   axi.rdata,        64'd0);
    chk("rst resp",    64'({axi.rresp, axi.bresp}), 64'd0);
    chk("rst irq",     64'(irq),         64'd0);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      if (tbl[k].wr) begin
        axi_write(tbl[k].addr, tbl[k].data, r);
        chk($sformatf("tbl%0d bresp", k), 64'(r), 64'(tbl[k].resp));
      end else begin
        axi_read(tbl[k].addr, d, r);
        chk($sformatf("tbl%0d rdata", k), d, tbl[k].exp);
        chk($sformatf("tbl%0d rresp", k), 64'(r), 64'(tbl[k].resp));
      end
    end

    // 1: basic counting, lane 3 += 2 for 10 cycles
    wr_ok(16'h0100, 64'h1F03);
    wr_ok(16'h0200, 64'h1);
    set_ev(3, 4'd2);
    repeat (10) @(posedge clk);
    @(negedge clk); events = '0;
    rd_chk(16'h0000, 64'd20);

    // 2: privilege filter on counter1 (lane 5, user only)
    level = 2'd1;
    wr_ok(16'h0108, 64'h1105);
    set_ev(5, 4'd1);
    repeat (5) @(posedge clk);
    @(negedge clk); events = '0;
    rd_chk(16'h0008, 64'd0);
    @(negedge clk); level = 2'd0; set_ev(5, 4'd1);
    repeat (7) @(posedge clk);
    @(negedge clk); events = '0;
    rd_chk(16'h0008, 64'd7);

    // 3: pid filter on counter3 (lane 6)
    wr_ok(16'h0118, 64'h5F06);
    wr_ok(16'h0200, 64'h0000_0042_0000_0001);
    pid = 32'h41; set_ev(6, 4'd3);
    repeat (4) @(posedge clk);
    @(negedge clk); events = '0;
    rd_chk(16'h0018, 64'd0);
    @(negedge clk); pid = 32'h42; set_ev(6, 4'd3);
    repeat (4) @(posedge clk);
    @(negedge clk); events = '0;
    rd_chk(16'h0018, 64'd12);

    // 4: overflow, irq, freeze, W1C
    wr_ok(16'h0110, 64'h3F07);
    wr_ok(16'h0010, 64'h0000_FFFF_FFFF_FFFF);
    set_ev(7, 4'd1);
    @(posedge clk);
    @(negedge clk); events = '0;
    chk("ovf irq", 64'(irq), 64'd1);
    rd_chk(16'h0010, 64'd0);
    rd_chk(16'h0208, 64'h4);
    wr_ok(16'h0200, 64'h0000_0042_0000_0003);
    @(negedge clk); set_ev(3, 4'd2); set_ev(7, 4'd1);
    repeat (5) @(posedge clk);
    @(negedge clk); events = '0;
    rd_chk(16'h0000, 64'd20);
    rd_chk(16'h0010, 64'd0);
    wr_ok(16'h0208, 64'h4);
    chk("w1c irq", 64'(irq), 64'd0);
    rd_chk(16'h0208, 64'h0);
    @(negedge clk); set_ev(7, 4'd1);
    repeat (3) @(posedge clk);
    @(negedge clk); events = '0;
    rd_chk(16'h0010, 64'd3);

    // 5: SW write of counter0 on the same edge as an increment of 5
    @(negedge clk);
    axi.awaddr = 16'h0000; axi.wdata = 64'd100; axi.awvalid = 1; axi.wvalid = 1; axi.bready = 0;
    @(negedge clk); axi.awvalid = 0; axi.wvalid = 0; set_ev(3, 4'd5);
    @(negedge clk); events = '0;
    chk("collide bvalid", 64'(axi.bvalid), 64'd1);
    axi.bready = 1;
    @(negedge clk); axi.bready = 0;
    rd_chk(16'h0000, 64'd100);

    // 6: W leads AW by 3 cycles, B back-pressured, concurrent read
    @(negedge clk);
    axi.wdata = 64'h1F01; axi.wvalid = 1; axi.awaddr = 16'h0120;
    @(negedge clk); axi.wvalid = 0;
    chk("w held wready", 64'(axi.wready), 64'd0);
    repeat (2) @(negedge clk);
    axi.awvalid = 1; axi.araddr = 16'h0000; axi.arvalid = 1;
    @(negedge clk); axi.awvalid = 0; axi.arvalid = 0;
    chk("conc rvalid", 64'(axi.rvalid), 64'd1);
    chk("conc rdata", axi.rdata, 64'd100);
    chk("conc bvalid early", 64'(axi.bvalid), 64'd0);
    axi.rready = 1;
    @(negedge clk); axi.rready = 0;
    chk("conc r done", 64'({axi.rvalid, axi.arready}), 64'b01);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("b held %0d", c), 64'({axi.bvalid, axi.bresp}), 64'b100);
      if (c < 3) @(negedge clk);
    end
    axi.bready = 1;
    @(negedge clk); axi.bready = 0;
    chk("b done", 64'({axi.bvalid, axi.awready, axi.wready}), 64'b011);
    repeat (2) @(negedge clk);
    chk("single b", 64'(axi.bvalid), 64'd0);
    rd_chk(16'h0120, 64'h1F01);

    // async reset mid-flight clears state
    @(negedge clk); axi.arvalid = 1; axi.araddr = 16'h0000;
    @(negedge clk); axi.arvalid = 0; #2 rst_n = 1'b0;
    #1 chk("async rst rvalid", 64'(axi.rvalid), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    rd_chk(16'h0000, 64'd0);
    rd_chk(16'h0108, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
